lcd_timing_driver: RTL and testbench
====================================

// Module: lcd_timing_driver
// PURPOSE
// - Panel-side timing generator for the parallel RGB565 LCD: produces HSYNC/VSYNC/DE and drives lcd_rgb.
// - Publishes the pixel coordinate one cycle ahead to the pixel-data generator (lcd_show) and accepts its
//   registered 16-bit pixel_data back, aligned so the returned data lands exactly on lcd_de.
// - Sits between the pattern/content layer and the panel pins; one pixel per sys_clk.
// PARAMETERS
// - H_SYNC  41   HSYNC pulse width, clocks
// - H_BACK  2    horizontal back porch, clocks
// - H_DISP  480  active pixels per line
// - H_FRONT 2    horizontal front porch, clocks
// - V_SYNC  10   VSYNC pulse width, lines
// - V_BACK  2    vertical back porch, lines
// - V_DISP  272  active lines per frame
// - V_FRONT 2    vertical front porch, lines
// - H_TOTAL = sum of H_* (525), V_TOTAL = sum of V_* (286); both must be < 2048.
// PORTS
// - sys_clk     in   1   pixel clock
// - sys_rst     in   1   async reset, active-low
// - pixel_data  in   16  RGB565 from content generator, registered there (1-cycle latency)
// - pixel_x     out  11  requested column, 0..H_DISP-1; 0 outside request window
// - pixel_y     out  11  requested row, 0..V_DISP-1; 0 outside request window
// - h_res       out  11  constant H_DISP
// - v_res       out  11  constant V_DISP
// - data_req    out  1   pixel_x/pixel_y valid this cycle
// - lcd_de      out  1   data enable to panel
// - lcd_hs      out  1   HSYNC, active-low
// - lcd_vs      out  1   VSYNC, active-low
// - lcd_bl      out  1   backlight enable
// - lcd_rgb     out  16  RGB565 to panel
// BEHAVIOUR
// - h_cnt 0..H_TOTAL-1, increments every clock, wraps to 0; v_cnt 0..V_TOTAL-1 increments when h_cnt wraps,
//   wraps to 0 when both are at their maximum (simultaneous wrap = frame boundary, both to 0 same edge).
// - Active window: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP-1] and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP-1].
// - data_req (combinational from counters) = v_cnt in active rows AND h_cnt in
//   [H_SYNC+H_BACK-1, H_SYNC+H_BACK+H_DISP-2], i.e. one clock ahead of the active window.
// - pixel_x = h_cnt-(H_SYNC+H_BACK-1), pixel_y = v_cnt-(V_SYNC+V_BACK) while data_req; else 0.
// - lcd_de = data_req registered 1 cycle; lcd_hs/lcd_vs registered 1 cycle from (h_cnt<H_SYNC)/(v_cnt<V_SYNC),
//   inverted (low during pulse) so all panel strobes share the same 1-cycle pipeline.
// - lcd_rgb = lcd_de ? pixel_data : 16'h0000 (black outside active area, no X leakage).
// - Latency: coordinate (x,y) presented at cycle N -> its pixel_data on lcd_rgb with lcd_de=1 at cycle N+1.
// - lcd_bl: 0 in reset, 1 from first clock after reset release.
// - Reset (async, any time incl. mid-line/mid-frame): h_cnt=v_cnt=0, lcd_de=0, lcd_hs=1, lcd_vs=1, lcd_bl=0;
//   pixel_x/pixel_y/data_req follow counters (=0). After release timing restarts at frame start (v_cnt=0, h_cnt=0);
//   no partial line is ever emitted with de=1.
// - h_res/v_res are constant, independent of reset.
// CONFIGURATION
// - LCD_DE_MODE_EN defined: panel runs DE-only; lcd_hs and lcd_vs held at 1 permanently (also in reset);
//   counters, data_req, lcd_de, lcd_rgb unchanged.
// - Not defined: HSYNC/VSYNC pulses generated as above.
// TESTING
// - Release reset, run 2 frames -> 525*286=150150 clocks/frame; lcd_de high exactly 480*272=130560 clocks/frame;
//   lcd_hs low 41 clocks per line, lcd_vs low 10 lines per frame.
// - First active line: data_req rises at h_cnt=42 with pixel_x=0, pixel_y=0; lcd_de rises at h_cnt=43;
//   last request pixel_x=479 at h_cnt=521, lcd_de falls after h_cnt=522.
// - Connect lcd_show model (5 bars) -> lcd_rgb = FFFF for de-columns 0..95, 0000 for 96..191, F800 for 192..287,
//   07E0 for 288..383, 001F for 384..479; lcd_rgb=0000 whenever lcd_de=0 even if pixel_data=FFFF.
// - Assert sys_rst low mid-line (v_cnt=100, h_cnt=200) for 3 clocks -> outputs immediately reset values;
//   after release next lcd_de rise occurs 12*525+43 clocks later.
// - Build with LCD_DE_MODE_EN -> lcd_hs=lcd_vs=1 for full 2 frames, lcd_de/lcd_rgb identical to default build.
// - Frame wrap: at h_cnt=524,v_cnt=285 -> next clock h_cnt=0,v_cnt=0, lcd_vs low on the following clock.

Source files
------------

// File: rtl/lcd_timing_driver_if.sv
// Content-side pixel request bus between the LCD timing driver
// and the pixel-data generator.
interface lcd_timing_driver_if;
  logic [15:0] pixel_data;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic [10:0] h_res;
  logic [10:0] v_res;
  logic        data_req;

  modport master (
    input  pixel_data,
    output pixel_x,
    output pixel_y,
    output h_res,
    output v_res,
    output data_req
  );

  modport slave (
    output pixel_data,
    input  pixel_x,
    input  pixel_y,
    input  h_res,
    input  v_res,
    input  data_req
  );
endinterface

// File: rtl/lcd_timing_driver.sv
// RGB565 LCD timing generator: HSYNC/VSYNC/DE, one-ahead pixel request.
// Define LCD_DE_MODE_EN for DE-only panels (HS/VS held high).
module lcd_timing_driver #(
  parameter int H_SYNC  = 41,
  parameter int H_BACK  = 2,
  parameter int H_DISP  = 480,
  parameter int H_FRONT = 2,
  parameter int V_SYNC  = 10,
  parameter int V_BACK  = 2,
  parameter int V_DISP  = 272,
  parameter int V_FRONT = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  lcd_timing_driver_if.master px,
  output logic                lcd_de,
  output logic                lcd_hs,
  output logic                lcd_vs,
  output logic                lcd_bl,
  output logic [15:0]         lcd_rgb
);

  localparam int H_TOTAL = H_SYNC + H_BACK
                         + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK
                         + V_DISP + V_FRONT;

  localparam logic [10:0] H_MAX =
    11'(H_TOTAL - 1);
  localparam logic [10:0] V_MAX =
    11'(V_TOTAL - 1);
  localparam logic [10:0] H_REQ0 =
    11'(H_SYNC + H_BACK - 1);
  localparam logic [10:0] H_REQ1 =
    11'(H_SYNC + H_BACK + H_DISP - 2);
  localparam logic [10:0] V_ACT0 =
    11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_ACT1 =
    11'(V_SYNC + V_BACK + V_DISP - 1);
  localparam logic [10:0] H_SYNC_W = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_W = 11'(V_SYNC);
  localparam logic [10:0] H_RES = 11'(H_DISP);
  localparam logic [10:0] V_RES = 11'(V_DISP);

  logic [10:0] h_cnt_q;
  logic [10:0] h_cnt_d;
  logic [10:0] v_cnt_q;
  logic [10:0] v_cnt_d;
  logic        de_q;
  logic        de_d;
  logic        bl_q;
  logic        h_wrap;
  logic        row_act;
  logic        col_req;
  logic        req;

  always_comb begin
    h_wrap  = (h_cnt_q == H_MAX);
    h_cnt_d = h_wrap ? 11'd0 : h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_MAX) ?
                11'd0 : v_cnt_q + 11'd1;
    end
  end

  // Request runs one clock ahead of the active window so the
  // generator's registered pixel lands exactly on lcd_de.
  always_comb begin
    row_act = (v_cnt_q >= V_ACT0)
           && (v_cnt_q <= V_ACT1);
    col_req = (h_cnt_q >= H_REQ0)
           && (h_cnt_q <= H_REQ1);
    req     = row_act && col_req;
    de_d    = req;
  end

  always_comb begin
    px.data_req = req;
    px.pixel_x  = 11'd0;
    px.pixel_y  = 11'd0;
    if (req) begin
      px.pixel_x = h_cnt_q - H_REQ0;
      px.pixel_y = v_cnt_q - V_ACT0;
    end
    px.h_res = H_RES;
    px.v_res = V_RES;
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      h_cnt_q <= 11'd0;
      v_cnt_q <= 11'd0;
      de_q    <= 1'b0;
      bl_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      de_q    <= de_d;
      bl_q    <= 1'b1;
    end
  end

`ifdef LCD_DE_MODE_EN
  assign lcd_hs = 1'b1;
  assign lcd_vs = 1'b1;
`else
  logic hs_q;
  logic hs_d;
  logic vs_q;
  logic vs_d;

  // Sync strobes share the DE pipeline stage.
  always_comb begin
    hs_d = !(h_cnt_q < H_SYNC_W);
    vs_d = !(v_cnt_q < V_SYNC_W);
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      hs_q <= hs_d;
      vs_q <= vs_d;
    end
  end

  assign lcd_hs = hs_q;
  assign lcd_vs = vs_q;
`endif

  assign lcd_de  = de_q;
  assign lcd_bl  = bl_q;
  assign lcd_rgb = de_q ? px.pixel_data : 16'h0000;

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Directed bench for lcd_timing_driver: default panel timing plus a
// small-geometry instance for whole-frame counts and frame wrap.
module tb_lcd_timing_driver;

`ifdef LCD_DE_MODE_EN
  localparam bit DEM = 1'b1;
`else
  localparam bit DEM = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic rst2_n;

  lcd_timing_driver_if bus_d ();
  lcd_timing_driver_if bus_s ();

  logic        d_de, d_hs, d_vs, d_bl;
  logic [15:0] d_rgb;
  logic        s_de, s_hs, s_vs, s_bl;
  logic [15:0] s_rgb;

  int n_chk;
  int n_fail;
  int k;

  lcd_timing_driver u_dut (
    .sys_clk (clk),
    .sys_rst (rst_n),
    .px      (bus_d),
    .lcd_de  (d_de),
    .lcd_hs  (d_hs),
    .lcd_vs  (d_vs),
    .lcd_bl  (d_bl),
    .lcd_rgb (d_rgb)
  );

  // 15 x 8 geometry: 120 clocks per frame
  lcd_timing_driver #(
    .H_SYNC (3), .H_BACK (2),
    .H_DISP (8), .H_FRONT(2),
    .V_SYNC (2), .V_BACK (1),
    .V_DISP (4), .V_FRONT(1)
  ) u_small (
    .sys_clk (clk),
    .sys_rst (rst2_n),
    .px      (bus_s),
    .lcd_de  (s_de),
    .lcd_hs  (s_hs),
    .lcd_vs  (s_vs),
    .lcd_bl  (s_bl),
    .lcd_rgb (s_rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lcd_show content model: five vertical bars, registered
  always @(posedge clk) begin
    if (bus_d.pixel_x < 11'd96)
      bus_d.pixel_data <= 16'hFFFF;
    else if (bus_d.pixel_x < 11'd192)
      bus_d.pixel_data <= 16'h0000;
    else if (bus_d.pixel_x < 11'd288)
      bus_d.pixel_data <= 16'hF800;
    else if (bus_d.pixel_x < 11'd384)
      bus_d.pixel_data <= 16'h07E0;
    else
      bus_d.pixel_data <= 16'h001F;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic goto(input int t);
    while (k < t) tick(1);
  endtask

  function automatic logic [15:0] bar(input int c);
    case (c / 96)
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      2:       return 16'hF800;
      3:       return 16'h07E0;
      default: return 16'h001F;
    endcase
  endfunction

  initial begin
    int de_n, hs_n, vs_n, bad, n;
    n_chk  = 0;
    n_fail = 0;
    k      = 0;
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    bus_s.pixel_data = 16'hFFFF;
    repeat (3) @(negedge clk);

    // ---- small geometry: whole frames ----
    chk("s_rst_de", 32'(s_de), 0);
    chk("s_rst_bl", 32'(s_bl), 0);
    chk("s_rst_hs", 32'(s_hs), 1);
    chk("s_rst_vs", 32'(s_vs), 1);
    chk("s_hres", 32'(bus_s.h_res), 8);
    rst2_n = 1'b1;
    k = 0;
    tick(1);
    chk("s_bl_on", 32'(s_bl), 1);
    de_n = 0; hs_n = 0; vs_n = 0; bad = 0;
    for (int i = 0; i < 120; i++) begin
      if (i > 0) tick(1);
      if (s_de) de_n++;
      if (!s_hs) hs_n++;
      if (!s_vs) vs_n++;
      if (s_rgb !== (s_de ? 16'hFFFF : 16'h0000))
        bad++;
    end
    chk("s_de_cnt", 32'(de_n), 32);
    chk("s_hs_cnt", 32'(hs_n), DEM ? 0 : 24);
    chk("s_vs_cnt", 32'(vs_n), DEM ? 0 : 30);
    chk("s_rgb_gate", 32'(bad), 0);
    chk("s_wrap_vs0", 32'(s_vs), 1);
    chk("s_wrap_req", 32'(bus_s.data_req), 0);
    tick(1);
    chk("s_wrap_vs1", 32'(s_vs), DEM ? 1 : 0);
    goto(169);
    chk("s_req_on", 32'(bus_s.data_req), 1);
    chk("s_px0", 32'(bus_s.pixel_x), 0);
    chk("s_py0", 32'(bus_s.pixel_y), 0);
    goto(176);
    chk("s_px7", 32'(bus_s.pixel_x), 7);
    goto(177);
    chk("s_req_off", 32'(bus_s.data_req), 0);
    chk("s_de_tail", 32'(s_de), 1);
    goto(178);
    chk("s_de_off", 32'(s_de), 0);
    goto(214);
    chk("s_py3", 32'(bus_s.pixel_y), 3);

    // ---- default geometry ----
    chk("rst_de", 32'(d_de), 0);
    chk("rst_hs", 32'(d_hs), 1);
    chk("rst_vs", 32'(d_vs), 1);
    chk("rst_bl", 32'(d_bl), 0);
    chk("rst_req", 32'(bus_d.data_req), 0);
    chk("rst_px", 32'(bus_d.pixel_x), 0);
    chk("rst_rgb", 32'(d_rgb), 0);
    chk("h_res", 32'(bus_d.h_res), 480);
    chk("v_res", 32'(bus_d.v_res), 272);
    rst_n = 1'b1;
    k = 0;
    tick(1);
    chk("bl_on", 32'(d_bl), 1);
    chk("hs_first", 32'(d_hs), DEM ? 1 : 0);
    chk("vs_first", 32'(d_vs), DEM ? 1 : 0);
    hs_n = 0; de_n = 0;
    for (int i = 0; i < 525; i++) begin
      if (i > 0) tick(1);
      if (!d_hs) hs_n++;
      if (d_de) de_n++;
    end
    chk("hs_line", 32'(hs_n), DEM ? 0 : 41);
    chk("de_blank", 32'(de_n), 0);
    goto(5250);
    chk("vs_last", 32'(d_vs), DEM ? 1 : 0);
    tick(1);
    chk("vs_end", 32'(d_vs), 1);
    goto(6341);
    chk("req_pre", 32'(bus_d.data_req), 0);
    tick(1);
    chk("req_rise", 32'(bus_d.data_req), 1);
    chk("req_px0", 32'(bus_d.pixel_x), 0);
    chk("req_py0", 32'(bus_d.pixel_y), 0);
    chk("de_pre", 32'(d_de), 0);
    tick(1);
    chk("de_rise", 32'(d_de), 1);
    chk("px1", 32'(bus_d.pixel_x), 1);
    de_n = 0;
    for (int c = 0; c < 480; c++) begin
      if (c > 0) tick(1);
      if (d_de) de_n++;
      if (c == 478)
        chk("px479", 32'(bus_d.pixel_x), 479);
      if ((c % 96 == 0) || (c % 96 == 95))
        chk($sformatf("bar_c%0d", c),
            32'(d_rgb), 32'(bar(c)));
    end
    chk("de_line", 32'(de_n), 480);
    chk("req_fall", 32'(bus_d.data_req), 0);
    tick(1);
    chk("de_fall", 32'(d_de), 0);
    chk("rgb_black", 32'(d_rgb), 0);
    goto(6867);
    chk("py1", 32'(bus_d.pixel_y), 1);
    chk("py1_px0", 32'(bus_d.pixel_x), 0);

    // ---- mid-line reset ----
    goto(10700);
    chk("de_mid", 32'(d_de), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_de", 32'(d_de), 0);
    chk("mr_hs", 32'(d_hs), 1);
    chk("mr_vs", 32'(d_vs), 1);
    chk("mr_bl", 32'(d_bl), 0);
    chk("mr_req", 32'(bus_d.data_req), 0);
    chk("mr_rgb", 32'(d_rgb), 0);
    tick(3);
    chk("mr_hold", 32'(d_de), 0);
    rst_n = 1'b1;
    k = 0;
    n = 0;
    while (!d_de && n < 10000) begin
      tick(1);
      n++;
    end
    chk("mr_de_rise", 32'(n), 6343);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
